// File: rtl/picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : picorv32_mem_arbiter
// Desc     : Round-robin arbiter sharing one picorv32 native memory port
//            between two masters, with a bus-timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module picorv32_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] ERR_RDATA      = 32'hBADB_AD00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout,
  output logic        timeout_flag
);

  localparam int unsigned WD_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT_CYCLES == 0) ? '0 : WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              timeout_flag_q, timeout_flag_d;

  logic              sel_m1;
  logic              busy;
  logic              cur_valid;
  logic              active;
  logic              wd_hit;
  logic              done;

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    wd_cnt_d       = wd_cnt_q;
    timeout_flag_d = timeout_flag_q;

    sel_m1    = (state_q == ST_BUSY1);
    busy      = (state_q == ST_BUSY0) || (state_q == ST_BUSY1);
    cur_valid = sel_m1 ? m1_valid : m0_valid;
    active    = busy && cur_valid;

    s_valid = active;
    s_instr = sel_m1 ? m1_instr : m0_instr;
    s_addr  = sel_m1 ? m1_addr  : m0_addr;
    s_wdata = sel_m1 ? m1_wdata : m0_wdata;
    s_wstrb = sel_m1 ? m1_wstrb : m0_wstrb;
    grant   = {state_q == ST_BUSY1, state_q == ST_BUSY0};

    // A real slave response in the deadline cycle takes priority over the watchdog.
    wd_hit  = (TIMEOUT_CYCLES != 0) && active && !s_ready && (wd_cnt_q == WD_LAST);
    done    = active && (s_ready || wd_hit);
    timeout = wd_hit;

    m0_ready = done && (state_q == ST_BUSY0);
    m1_ready = done && (state_q == ST_BUSY1);
    m0_rdata = (wd_hit && state_q == ST_BUSY0) ? ERR_RDATA : s_rdata;
    m1_rdata = (wd_hit && state_q == ST_BUSY1) ? ERR_RDATA : s_rdata;

    if (wd_hit) timeout_flag_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        wd_cnt_d = '0;
        if (m0_valid && m1_valid) begin
          state_d = last_grant_q ? ST_BUSY0 : ST_BUSY1;
        end else if (m0_valid) begin
          state_d = ST_BUSY0;
        end else if (m1_valid) begin
          state_d = ST_BUSY1;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (!cur_valid) begin
          // Master withdrew its request: drop the transaction without a ready.
          state_d = ST_IDLE;
        end else if (done) begin
          state_d      = ST_IDLE;
          last_grant_d = sel_m1;
        end else if (wd_cnt_q != WD_MAX) begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign timeout_flag = timeout_flag_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= 1'b1;
      wd_cnt_q       <= '0;
      timeout_flag_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      wd_cnt_q       <= wd_cnt_d;
      timeout_flag_q <= timeout_flag_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_picorv32_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_picorv32_mem_arbiter
// Desc     : Directed self-checking bench for picorv32_mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_picorv32_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_valid, m0_instr, m1_valid, m1_instr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_instr, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant;
  logic        timeout, timeout_flag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  picorv32_mem_arbiter #(
    .TIMEOUT_CYCLES (4),
    .ERR_RDATA      (32'hBADB_AD00)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .m0_valid     (m0_valid),
    .m0_instr     (m0_instr),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m0_wstrb     (m0_wstrb),
    .m0_ready     (m0_ready),
    .m0_rdata     (m0_rdata),
    .m1_valid     (m1_valid),
    .m1_instr     (m1_instr),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m1_wstrb     (m1_wstrb),
    .m1_ready     (m1_ready),
    .m1_rdata     (m1_rdata),
    .s_valid      (s_valid),
    .s_instr      (s_instr),
    .s_addr       (s_addr),
    .s_wdata      (s_wdata),
    .s_wstrb      (s_wstrb),
    .s_ready      (s_ready),
    .s_rdata      (s_rdata),
    .grant        (grant),
    .timeout      (timeout),
    .timeout_flag (timeout_flag)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Complete the currently granted transaction with a single-cycle slave response.
  task automatic respond(input logic [31:0] data);
    s_ready = 1'b1;
    s_rdata = data;
    settle();
  endtask

  task automatic release_all();
    tick();
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    s_ready  = 1'b0;
    settle();
  endtask

  initial begin
    reset = 1'b1;
    m0_valid = 0; m0_instr = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_valid = 0; m1_instr = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    s_ready = 0; s_rdata = 0;
    tick();
    tick();
    reset = 1'b0;
    settle();
    chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
    chk("rst_grant", {30'd0, grant}, 32'd0);
    chk("rst_ready", {30'd0, m1_ready, m0_ready}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_flag", {31'd0, timeout_flag}, 32'd0);

    // Single m0 read, slave answers two cycles after s_valid rises.
    m0_valid = 1; m0_addr = 32'h100; m0_wstrb = 4'h0; m0_instr = 1;
    settle();
    chk("t1_arb_cycle_s_valid", {31'd0, s_valid}, 32'd0);
    tick();
    chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
    chk("t1_s_addr", s_addr, 32'h100);
    chk("t1_s_instr", {31'd0, s_instr}, 32'd1);
    chk("t1_grant", {30'd0, grant}, 32'd1);
    chk("t1_no_ready_early", {31'd0, m0_ready}, 32'd0);
    tick();
    chk("t1_no_ready_c2", {31'd0, m0_ready}, 32'd0);
    tick();
    respond(32'hDEADBEEF);
    chk("t1_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("t1_timeout", {31'd0, timeout}, 32'd0);
    release_all();
    chk("t1_idle_grant", {30'd0, grant}, 32'd0);
    chk("t1_idle_ready", {31'd0, m0_ready}, 32'd0);
    m0_instr = 0;

    // Simultaneous requests after reset alternate m0, m1, m0, m1.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < 2; r++) begin
      m0_valid = 1; m0_addr = 32'h10;
      m1_valid = 1; m1_addr = 32'h20;
      settle();
      tick();
      chk($sformatf("t2_r%0d_first_grant", r), {30'd0, grant}, 32'd1);
      chk($sformatf("t2_r%0d_first_addr", r), s_addr, 32'h10);
      respond(32'h0000_0A0A);
      chk($sformatf("t2_r%0d_m0_ready", r), {30'd0, m1_ready, m0_ready}, 32'd1);
      tick();
      m0_valid = 0; s_ready = 0;
      settle();
      chk($sformatf("t2_r%0d_gap_grant", r), {30'd0, grant}, 32'd0);
      tick();
      chk($sformatf("t2_r%0d_second_grant", r), {30'd0, grant}, 32'd2);
      chk($sformatf("t2_r%0d_second_addr", r), s_addr, 32'h20);
      respond(32'h0000_0B0B);
      chk($sformatf("t2_r%0d_m1_ready", r), {30'd0, m1_ready, m0_ready}, 32'd2);
      chk($sformatf("t2_r%0d_m1_rdata", r), m1_rdata, 32'h0000_0B0B);
      release_all();
    end

    // m1 write in flight; m0 request waits until m1 completes and an idle cycle passes.
    m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
    settle();
    tick();
    m0_valid = 1; m0_addr = 32'h300; m0_wstrb = 4'h0;
    settle();
    chk("t3_s_addr", s_addr, 32'h200);
    chk("t3_s_wdata", s_wdata, 32'h1234_5678);
    chk("t3_s_wstrb", {28'd0, s_wstrb}, 32'hF);
    chk("t3_m0_wait", {31'd0, m0_ready}, 32'd0);
    tick();
    chk("t3_s_addr_hold", s_addr, 32'h200);
    chk("t3_grant_hold", {30'd0, grant}, 32'd2);
    tick();
    respond(32'h0);
    chk("t3_m1_ready", {30'd0, m1_ready, m0_ready}, 32'd2);
    tick();
    m1_valid = 0; m1_wstrb = 0; s_ready = 0;
    settle();
    chk("t3_idle_gap", {30'd0, grant}, 32'd0);
    tick();
    chk("t3_m0_grant", {30'd0, grant}, 32'd1);
    chk("t3_m0_addr", s_addr, 32'h300);
    respond(32'h5555_AAAA);
    chk("t3_m0_rdata", m0_rdata, 32'h5555_AAAA);
    release_all();

    // Slave answers exactly on the 4th busy cycle: real data wins, no timeout.
    m0_valid = 1; m0_addr = 32'h400;
    settle();
    tick();
    tick();
    tick();
    chk("t5_no_ready_c3", {31'd0, m0_ready}, 32'd0);
    tick();
    respond(32'hCAFE_F00D);
    chk("t5_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t5_m0_rdata", m0_rdata, 32'hCAFE_F00D);
    chk("t5_timeout", {31'd0, timeout}, 32'd0);
    release_all();
    chk("t5_flag", {31'd0, timeout_flag}, 32'd0);

    // Slave never answers: watchdog completes on the 4th busy cycle.
    m0_valid = 1; m0_addr = 32'h500;
    settle();
    tick();
    chk("t4_timeout_c1", {31'd0, timeout}, 32'd0);
    tick();
    tick();
    chk("t4_no_ready_c3", {31'd0, m0_ready}, 32'd0);
    chk("t4_timeout_c3", {31'd0, timeout}, 32'd0);
    tick();
    chk("t4_m0_ready", {31'd0, m0_ready}, 32'd1);
    chk("t4_m0_rdata", m0_rdata, 32'hBADB_AD00);
    chk("t4_timeout", {31'd0, timeout}, 32'd1);
    release_all();
    chk("t4_timeout_pulse_end", {31'd0, timeout}, 32'd0);
    chk("t4_flag", {31'd0, timeout_flag}, 32'd1);
    tick();
    tick();
    chk("t4_flag_sticky", {31'd0, timeout_flag}, 32'd1);

    // Reset during BUSY1 drops the request; m0 then wins the next arbitration.
    m1_valid = 1; m1_addr = 32'h600;
    settle();
    tick();
    chk("t6_busy1", {30'd0, grant}, 32'd2);
    m0_valid = 1; m0_addr = 32'h700;
    reset = 1'b1;
    settle();
    chk("t6_m1_ready_in_rst", {31'd0, m1_ready}, 32'd0);
    tick();
    reset = 1'b0;
    settle();
    chk("t6_s_valid", {31'd0, s_valid}, 32'd0);
    chk("t6_grant", {30'd0, grant}, 32'd0);
    chk("t6_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("t6_flag_cleared", {31'd0, timeout_flag}, 32'd0);
    tick();
    chk("t6_m0_first", {30'd0, grant}, 32'd1);
    chk("t6_m0_addr", s_addr, 32'h700);
    respond(32'h1);
    chk("t6_m0_ready", {30'd0, m1_ready, m0_ready}, 32'd1);
    tick();
    m0_valid = 0; s_ready = 0;
    settle();
    tick();
    chk("t6_m1_after", {30'd0, grant}, 32'd2);
    release_all();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
